// File: rtl/lms_core_param.sv
// Sequential N-tap adaptive LMS filter: one MAC per cycle, then the error, then one
// weight update per cycle (sign-error or full LMS) unless the sample was taken frozen.
module lms_core_param #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int TAPS     = 8,
  parameter int MU_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] d_in,
  input  logic        [1:0]       mode,
  input  logic                    w_clr,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] e_out
);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;

  // Clamp any intermediate (already sign-extended to ACC_W) into the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  state_t                  state;
  logic signed [WIDTH-1:0] x_dl [TAPS];
  logic signed [WIDTH-1:0] w    [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [WIDTH-1:0] d_lat;
  logic        [1:0]       mode_lat;
  logic        [IDX_W-1:0] idx;

  logic signed [PROD_W-1:0] mac_prod;
  logic signed [PROD_W-1:0] upd_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [WIDTH-1:0]  y_calc;
  logic signed [WIDTH-1:0]  e_calc;
  logic signed [WIDTH-1:0]  x_mu;
  logic signed [WIDTH-1:0]  w_next;

  assign in_ready = (state == IDLE) && !w_clr;

  // The update uses the registered error, so y/e always reflect pre-update weights.
  always_comb begin
    mac_prod = PROD_W'(w[idx]) * PROD_W'(x_dl[idx]);
    y_calc   = sat(acc >>> FRAC);
    e_calc   = sat(ACC_W'(d_lat) - ACC_W'(y_calc));
    upd_prod = PROD_W'(e_out) * PROD_W'(x_dl[idx]);
    x_mu     = x_dl[idx] >>> MU_SHIFT;
    w_sum    = ACC_W'(w[idx]);
    if (mode_lat == 2'd1)
      w_sum = ACC_W'(w[idx]) + ACC_W'(upd_prod >>> (FRAC + MU_SHIFT));
    else if (e_out > 0)
      w_sum = ACC_W'(w[idx]) + ACC_W'(x_mu);
    else if (e_out < 0)
      w_sum = ACC_W'(w[idx]) - ACC_W'(x_mu);
    w_next = sat(w_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      d_lat     <= '0;
      mode_lat  <= '0;
      y_out     <= '0;
      e_out     <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_dl[i] <= '0;
        w[i]    <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (w_clr) begin
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
          end else if (in_valid) begin
            x_dl[0] <= x_in;
            for (int i = 1; i < TAPS; i++) x_dl[i] <= x_dl[i-1];
            d_lat    <= d_in;
            mode_lat <= mode;
            acc      <= '0;
            idx      <= '0;
            state    <= MAC;
          end
        end
        // One tap per cycle into the growth-guarded accumulator.
        MAC: begin
          acc <= acc + ACC_W'(mac_prod);
          if (idx == LAST_IDX) state <= ERR;
          else                 idx   <= idx + IDX_W'(1);
        end
        ERR: begin
          y_out     <= y_calc;
          e_out     <= e_calc;
          out_valid <= 1'b1;
          idx       <= '0;
          state     <= mode_lat[1] ? IDLE : UPD;
        end
        // One weight per cycle; the delay line is frozen until the next acceptance.
        UPD: begin
          w[idx] <= w_next;
          if (idx == LAST_IDX) state <= IDLE;
          else                 idx   <= idx + IDX_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_core_param.sv
// Directed bench for lms_core_param (WIDTH=16, FRAC=8, TAPS=4, MU_SHIFT=4); weights are
// read back through frozen probe samples that place 256 at one delay-line position.
module tb_lms_core_param;
  localparam int WIDTH    = 16;
  localparam int FRAC     = 8;
  localparam int TAPS     = 4;
  localparam int MU_SHIFT = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    w_clr = 1'b0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [WIDTH-1:0] x_in = '0;
  logic signed [WIDTH-1:0] d_in = '0;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] e_out;
  logic        [1:0]       mode = 2'd0;

  int n_vec = 0;
  int n_bad = 0;
  int wr [TAPS];

  lms_core_param #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .MU_SHIFT(MU_SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .d_in(d_in), .mode(mode), .w_clr(w_clr),
    .out_valid(out_valid), .y_out(y_out), .e_out(e_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; w_clr = 1'b0; in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
  endtask

  // Returns one cycle after acceptance edge 0; inputs are scrambled afterwards.
  task automatic accept(input int x, input int d, input logic [1:0] m);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (n >= 100) check_val("tmo_ready", 0, 1);
    x_in = 16'(x); d_in = 16'(d); mode = m; in_valid = 1'b1;
    step();
    in_valid = 1'b0; x_in = 16'($urandom); d_in = 16'($urandom); mode = 2'($urandom);
  endtask

  // lat = edges from acceptance to out_valid; rdy = edge of earliest next acceptance.
  task automatic send(input int x, input int d, input logic [1:0] m, input bit clr_mac,
                      output int y, output int e, output int lat, output int rdy);
    accept(x, d, m);
    lat = 0;
    if (clr_mac) begin
      w_clr = 1'b1; step(); step(); w_clr = 1'b0;
      lat = 2;
    end
    while (!out_valid && lat < 50) begin step(); lat++; end
    if (lat >= 50) check_val("tmo_out_valid", 0, 1);
    y = y_out;
    e = e_out;
    rdy = lat;
    while (!in_ready && rdy < 50) begin step(); rdy++; end
    if (rdy >= 50) check_val("tmo_idle", 0, 1);
    rdy = rdy + 1;
  endtask

  task automatic read_weights();
    int y, e, l, r;
    for (int i = 0; i < TAPS; i++) send(0, 0, 2'd2, 1'b0, y, e, l, r);
    send(256, 0, 2'd2, 1'b0, y, e, l, r);
    wr[0] = y;
    for (int i = 1; i < TAPS; i++) begin
      send(0, 0, 2'd2, 1'b0, y, e, l, r);
      wr[i] = y;
    end
  endtask

  task automatic count_no_out(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    int y, e, lat, rdy, n;
    int acc_at [3];
    int n_acc, pulses, hi;
    logic prev;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_y", int'(y_out), 0);
    check_val("rst_e", int'(e_out), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_in_ready", int'(in_ready), 1);

    // Sign mode
    send(256, 512, 2'd0, 1'b0, y, e, lat, rdy);
    check_val("sign1_y", y, 0);
    check_val("sign1_e", e, 512);
    check_val("sign1_latency", lat, 5);
    check_val("sign1_next_accept", rdy, 10);
    read_weights();
    check_val("sign_w0", wr[0], 16);
    check_val("sign_w1", wr[1], 0);
    check_val("sign_w2", wr[2], 0);
    check_val("sign_w3", wr[3], 0);
    send(256, 512, 2'd0, 1'b0, y, e, lat, rdy);
    check_val("sign2_y", y, 16);
    check_val("sign2_e", e, 496);

    // Full mode
    do_reset();
    send(256, 512, 2'd1, 1'b0, y, e, lat, rdy);
    check_val("full_y", y, 0);
    check_val("full_e", e, 512);
    read_weights();
    check_val("full_w0", wr[0], 32);
    check_val("full_w1", wr[1], 0);
    check_val("full_w2", wr[2], 0);
    check_val("full_w3", wr[3], 0);

    // Frozen with saturated error
    do_reset();
    send(256, 512, 2'd0, 1'b0, y, e, lat, rdy);
    send(256, -32768, 2'd2, 1'b0, y, e, lat, rdy);
    check_val("frz_y", y, 16);
    check_val("frz_e_sat", e, -32768);
    check_val("frz_latency", lat, 5);
    check_val("frz_next_accept", rdy, 6);
    read_weights();
    check_val("frz_w0", wr[0], 16);
    check_val("frz_w1", wr[1], 0);

    // Weight saturation under full LMS
    do_reset();
    send(32767, 32767, 2'd1, 1'b0, y, e, lat, rdy);
    check_val("wsat1_e", e, 32767);
    send(32767, 32767, 2'd1, 1'b0, y, e, lat, rdy);
    check_val("wsat2_y_sat", y, 32767);
    check_val("wsat2_e", e, 0);
    send(32767, 32767, 2'd1, 1'b0, y, e, lat, rdy);
    read_weights();
    check_val("wsat_w0", wr[0], 32767);
    check_val("wsat_w1", wr[1], 0);

    // Continuous in_valid
    do_reset();
    x_in = '0; d_in = '0; mode = 2'd0; in_valid = 1'b1;
    n_acc = 0; pulses = 0; hi = 0; prev = 1'b0;
    acc_at = '{0, 0, 0};
    for (int c = 0; c < 35; c++) begin
      if (in_ready) begin
        if (n_acc < 3) acc_at[n_acc] = c;
        n_acc++;
      end
      if (out_valid) begin
        hi++;
        if (!prev) pulses++;
      end
      prev = out_valid;
      step();
    end
    in_valid = 1'b0;
    check_val("hs_accepts", n_acc, 4);
    check_val("hs_spacing1", acc_at[1] - acc_at[0], 10);
    check_val("hs_spacing2", acc_at[2] - acc_at[1], 10);
    check_val("hs_pulses", pulses, 3);
    check_val("hs_pulse_cycles", hi, 3);

    // w_clr during MAC is ignored, w_clr in IDLE clears and blocks acceptance
    do_reset();
    send(256, 512, 2'd0, 1'b0, y, e, lat, rdy);
    send(0, 0, 2'd2, 1'b1, y, e, lat, rdy);
    read_weights();
    check_val("clr_mac_w0", wr[0], 16);
    w_clr = 1'b1; in_valid = 1'b1; x_in = 16'(256); mode = 2'd2;
    #1;
    check_val("clr_idle_in_ready", int'(in_ready), 0);
    step();
    w_clr = 1'b0; in_valid = 1'b0;
    count_no_out("clr_idle_no_accept");
    read_weights();
    check_val("clr_idle_w0", wr[0], 0);
    check_val("clr_idle_w1", wr[1], 0);

    // Reset during MAC
    do_reset();
    accept(256, 512, 2'd0);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    count_no_out("rst_mac_no_out");

    // Reset during UPD
    do_reset();
    send(256, 512, 2'd0, 1'b0, y, e, lat, rdy);
    accept(256, 512, 2'd0);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (n >= 20) check_val("tmo_rst_upd", 0, 1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check_val("rst_upd_out_valid", int'(out_valid), 0);
    count_no_out("rst_upd_no_out");
    read_weights();
    check_val("rst_upd_w0", wr[0], 0);
    check_val("rst_upd_w1", wr[1], 0);
    check_val("rst_upd_w2", wr[2], 0);
    check_val("rst_upd_w3", wr[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
